// File: rtl/dpa_im_pkg.sv
// Shared definitions for the DPA image-memory port.
// Provides the default IM address/data widths, the requester index
// constants and the arbiter state encoding.
package dpa_im_pkg;

  localparam int IM_AW = 20;
  localparam int IM_DW = 24;

  localparam logic [1:0] REQ_PHOTO = 2'd0;
  localparam logic [1:0] REQ_TIME  = 2'd1;
  localparam logic [1:0] REQ_HOST  = 2'd2;

  typedef enum logic {
    IM_ARB_IDLE = 1'b0,
    IM_ARB_OWN  = 1'b1
  } im_arb_state_e;

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker.
// Searches req in the order last+1, last+2, last (mod 3).
//   req  : request vector, one bit per requester
//   last : index of the previous winner
//   win  : one-hot winner (0 when req == 0)
//   idx  : winner index (equals last when req == 0)
module rr_pick3
  import dpa_im_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] win,
  output logic [1:0] idx
);

  logic [1:0] o0, o1, o2;

  always_comb begin
    case (last)
      REQ_PHOTO: begin o0 = REQ_TIME;  o1 = REQ_HOST;  o2 = REQ_PHOTO; end
      REQ_TIME:  begin o0 = REQ_HOST;  o1 = REQ_PHOTO; o2 = REQ_TIME;  end
      default:   begin o0 = REQ_PHOTO; o1 = REQ_TIME;  o2 = REQ_HOST;  end
    endcase
  end

  always_comb begin
    win = 3'b000;
    idx = last;
    if (req[o0]) begin
      idx = o0;
      win = 3'b001 << o0;
    end else if (req[o1]) begin
      idx = o1;
      win = 3'b001 << o1;
    end else if (req[o2]) begin
      idx = o2;
      win = 3'b001 << o2;
    end
  end

endmodule

// File: rtl/im_arb.sv
// Single-port image-memory arbiter: round-robin with a bounded burst lock
// between photo (0), time overlay (1) and host (2) requesters.
//   clk, reset           : clock, async active-high reset
//   req, we              : per-requester request and write qualifier
//   addr0..2, wdata0..2  : per-requester address / write data
//   gnt                  : one-hot grant (combinational)
//   im_a, im_wen_n, im_d : registered IM pins
//   im_q                 : IM read data, valid the cycle after im_a
//   rvalid, rdata        : one-hot read return strobe and data
//
// state       | meaning
// IM_ARB_IDLE | no access was issued last cycle
// IM_ARB_OWN  | last cycle granted holder
module im_arb
  import dpa_im_pkg::*;
#(
  parameter int AW    = IM_AW,
  parameter int DW    = IM_DW,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [2:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    gnt,
  output logic [AW-1:0] im_a,
  output logic          im_wen_n,
  output logic [DW-1:0] im_d,
  input  logic [DW-1:0] im_q,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata
);

  localparam logic [3:0] BURST_LIM = 4'(BURST - 1);

  im_arb_state_e state;
  logic [1:0]    holder;
  logic [3:0]    burst_cnt;

  logic [2:0]    pick_win;
  logic [1:0]    pick_idx;
  logic [2:0]    holder_oh;
  logic          lock;
  logic [1:0]    win_idx;

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

  // Source tag follows the access: stage 1 aligns with the pins,
  // stage 2 with im_q, and rvalid is the registered stage 2.
  logic [2:0]    tag_iss;
  logic [2:0]    tag_q;

  rr_pick3 u_pick (
    .req  (req),
    .last (holder),
    .win  (pick_win),
    .idx  (pick_idx)
  );

  always_comb begin
    holder_oh = 3'b001 << holder;
    // Holder keeps the port while under its burst budget, or indefinitely
    // when nobody else is asking.
    lock = (state == IM_ARB_OWN) && ((req & holder_oh) != 3'b000) &&
           ((burst_cnt < BURST_LIM) || ((req & ~holder_oh) == 3'b000));
    if (reset)
      gnt = 3'b000;
    else if (lock)
      gnt = holder_oh;
    else
      gnt = pick_win;
    win_idx = lock ? holder : pick_idx;
  end

  always_comb begin
    sel_addr  = addr0;
    sel_wdata = wdata0;
    sel_we    = we[0];
    case (win_idx)
      REQ_TIME: begin
        sel_addr  = addr1;
        sel_wdata = wdata1;
        sel_we    = we[1];
      end
      REQ_HOST: begin
        sel_addr  = addr2;
        sel_wdata = wdata2;
        sel_we    = we[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IM_ARB_IDLE;
      holder    <= REQ_HOST;
      burst_cnt <= 4'd0;
    end else if (req != 3'b000) begin
      state <= IM_ARB_OWN;
      if (lock) begin
        burst_cnt <= (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;
      end else begin
        holder    <= pick_idx;
        burst_cnt <= 4'd0;
      end
    end else begin
      // holder is kept so round-robin order survives idle gaps
      state     <= IM_ARB_IDLE;
      burst_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_a     <= '0;
      im_d     <= '0;
      im_wen_n <= 1'b1;
      tag_iss  <= 3'b000;
      tag_q    <= 3'b000;
      rvalid   <= 3'b000;
      rdata    <= '0;
    end else begin
      if (gnt != 3'b000) begin
        im_a     <= sel_addr;
        im_d     <= sel_wdata;
        im_wen_n <= ~sel_we;
        tag_iss  <= sel_we ? 3'b000 : gnt;
      end else begin
        im_wen_n <= 1'b1;
        tag_iss  <= 3'b000;
      end
      tag_q  <= tag_iss;
      rvalid <= tag_q;
      if (tag_q != 3'b000)
        rdata <= im_q;
    end
  end

endmodule

// File: tb/tb_im_arb.sv
// Directed self-checking bench for im_arb with a behavioural IM model.
// A second instance with BURST=1 shares the stimulus.
module tb_im_arb;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [19:0] addr0, addr1, addr2;
  logic [23:0] wdata0, wdata1, wdata2;
  logic [2:0]  gnt;
  logic [19:0] im_a;
  logic        im_wen_n;
  logic [23:0] im_d;
  logic [23:0] im_q;
  logic [2:0]  rvalid;
  logic [23:0] rdata;

  logic [2:0]  rr_gnt;
  logic [19:0] rr_im_a;
  logic        rr_im_wen_n;
  logic [23:0] rr_im_d;
  logic [2:0]  rr_rvalid;
  logic [23:0] rr_rdata;

  int n_chk = 0;
  int n_bad = 0;

  logic [23:0] mem [logic [19:0]];

  im_arb #(.AW(20), .DW(24), .BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .im_a(im_a), .im_wen_n(im_wen_n), .im_d(im_d),
    .im_q(im_q), .rvalid(rvalid), .rdata(rdata)
  );

  im_arb #(.AW(20), .DW(24), .BURST(1)) dut_rr (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(rr_gnt), .im_a(rr_im_a), .im_wen_n(rr_im_wen_n), .im_d(rr_im_d),
    .im_q(im_q), .rvalid(rr_rvalid), .rdata(rr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mem_rd(logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return {4'h5, a};
  endfunction

  // Synchronous IM: read data appears the cycle after the address.
  always @(posedge clk) begin
    im_q <= mem_rd(im_a);
    if (!im_wen_n) mem[im_a] = im_d;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int wait_cnt [3];
    int max_wait;
    int lows;
    logic [2:0] exp_g;

    reset = 1'b1;
    req = 3'b000; we = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
    im_q = '0;
    tick();
    tick();
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_wen", 32'(im_wen_n), 32'h1);
      chk("idle_a", 32'(im_a), 32'h0);
      chk("idle_rv", 32'(rvalid), 32'h0);
      tick();
    end

    // single requester streaming reads
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        req = 3'b001;
        addr0 = 20'h00010 + 20'(i);
      end else begin
        req = 3'b000;
      end
      #1;
      chk("rd_gnt", 32'(gnt), (i < 4) ? 32'h1 : 32'h0);
      if (i >= 1 && i <= 4) chk("rd_im_a", 32'(im_a), 32'h10 + 32'(i - 1));
      if (i >= 3 && i <= 6) begin
        chk("rd_rv", 32'(rvalid), 32'h1);
        chk("rd_data", 32'(rdata), {8'h0, 4'h5, 20'h00010 + 20'(i - 3)});
      end else begin
        chk("rd_rv0", 32'(rvalid), 32'h0);
      end
      tick();
    end

    // three requesters, burst of 4
    do_reset();
    we = 3'b000;
    addr0 = 20'h00100; addr1 = 20'h00200; addr2 = 20'h00300;
    req = 3'b111;
    for (int k = 0; k < 3; k++) wait_cnt[k] = 0;
    max_wait = 0;
    for (int i = 0; i < 24; i++) begin
      #1;
      exp_g = 3'b001 << ((i / 4) % 3);
      chk("rr4_gnt", 32'(gnt), 32'(exp_g));
      for (int k = 0; k < 3; k++) begin
        if (gnt[k]) wait_cnt[k] = 0;
        else wait_cnt[k]++;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
      tick();
    end
    chk("rr4_starve", 32'(max_wait <= 8), 32'h1);
    req = 3'b000;
    tick();
    tick();
    tick();

    // write then read same address
    do_reset();
    we = 3'b010;
    addr1 = 20'h12345; wdata1 = 24'hFFFFFF;
    addr2 = 20'h12345;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      req = (i == 0) ? 3'b110 : (i == 1) ? 3'b100 : 3'b000;
      #1;
      if (!im_wen_n) lows++;
      case (i)
        0: chk("wr_gnt1", 32'(gnt), 32'h2);
        1: begin
          chk("wr_gnt2", 32'(gnt), 32'h4);
          chk("wr_a", 32'(im_a), 32'h12345);
          chk("wr_wen", 32'(im_wen_n), 32'h0);
          chk("wr_d", 32'(im_d), 32'hFFFFFF);
        end
        2: chk("wr_rd_a", 32'(im_a), 32'h12345);
        4: begin
          chk("wr_rv", 32'(rvalid), 32'h4);
          chk("wr_rdata", 32'(rdata), 32'hFFFFFF);
        end
        default: chk("wr_rv0", 32'(rvalid), 32'h0);
      endcase
      tick();
    end
    chk("wr_lows", 32'(lows), 32'h1);

    // reset after a read grant
    do_reset();
    we = 3'b000;
    addr0 = 20'h00020;
    req = 3'b001;
    #1;
    chk("rst_rd_gnt", 32'(gnt), 32'h1);
    tick();
    req = 3'b000;
    chk("rst_rd_a", 32'(im_a), 32'h20);
    reset = 1'b1;
    #1;
    chk("rst_rd_wen", 32'(im_wen_n), 32'h1);
    chk("rst_rd_a0", 32'(im_a), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rst_rd_rv", 32'(rvalid), 32'h0);
      tick();
    end

    // reset after a write grant
    we = 3'b010;
    addr1 = 20'h00555; wdata1 = 24'h123456;
    req = 3'b010;
    #1;
    chk("rst_wr_gnt", 32'(gnt), 32'h2);
    tick();
    req = 3'b000;
    chk("rst_wr_pin", 32'(im_wen_n), 32'h0);
    reset = 1'b1;
    #1;
    chk("rst_wr_wen", 32'(im_wen_n), 32'h1);
    tick();
    chk("rst_wr_mem", 32'(mem_rd(20'h00555)), {8'h0, 4'h5, 20'h00555});
    tick();
    reset = 1'b0;
    tick();
    #1;
    chk("rst_wr_rv", 32'(rvalid), 32'h0);
    we = 3'b000;

    // BURST=1: pure alternation between 0 and 2
    do_reset();
    req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr1_gnt", 32'(rr_gnt), (i % 2 == 0) ? 32'h1 : 32'h4);
      tick();
    end
    req = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/im_arb.md
# im_arb

Single-port image-memory (IM) arbiter for the DPA device. It shares the one IM port between three requesters: the photo scale/copy engine, the time-overlay writer and the host/setup reader. Each cycle it grants at most one request, using round-robin order with a bounded burst lock. The block registers the winning access onto the IM pins and returns read data to the requester that issued it.

## Interface
- AW, 20, IM address width
- DW, 24, IM data width (one RGB pixel)
- BURST, 4, maximum consecutive grants to one requester while another requester is pending; legal range 1..15
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, asynchronous, active-high
- req  in  3  access request per requester (0 = photo, 1 = time overlay, 2 = host)
- we  in  3  per-requester write qualifier; 1 = write, 0 = read
- addr0, addr1, addr2  in  AW each  access address per requester
- wdata0, wdata1, wdata2  in  DW each  write data per requester
- gnt  out  3  one-hot grant, combinational from req and arbiter state
- im_a  out  AW  registered IM address
- im_wen_n  out  1  registered IM write enable, active-low
- im_d  out  DW  registered IM write data
- im_q  in  DW  IM read data; valid in the cycle after im_a is presented
- rvalid  out  3  one-hot read-return strobe
- rdata  out  DW  registered read data

## Operation
- State machine, two states:
  - IDLE: no access was issued in the previous cycle.
  - OWN: the previous cycle granted holder h.
- Registers: holder h (2 bits, reset 2'd2 so requester 0 wins first), burst_cnt (4 bits, reset 0).
- Grant rule for cycle t:
  - If state is OWN, req[h]=1, and either burst_cnt < BURST-1 or no other req is set: grant h again and increment burst_cnt (saturating at 15).
  - Otherwise: grant the first set req in the order h+1, h+2, h (mod 3); set h to the winner; clear burst_cnt.
  - If req == 0: gnt=0 and next state is IDLE. h is retained for round-robin order.
- A request is granted at most once per cycle. The requester advances its own address on a cycle where gnt[k]=1. A requester must keep req, we, addr and wdata stable until granted.
- Issue register, loaded at each rising edge:
  - On a grant: im_a=addr_k, im_d=wdata_k, im_wen_n=~we_k.
  - On no grant: im_wen_n=1; im_a and im_d hold their values.
- Read return:
  - A pipeline tag of 3 bits (one-hot source, 0 on writes) follows the issue register.
  - One cycle after a read is issued, rdata<=im_q and rvalid<=tag.
  - rvalid is zero on all other cycles.
- Addresses are passed through unmodified. No arithmetic is done on addresses; no wrap or bounds checking.
- Reset values: gnt=0, im_a=0, im_wen_n=1, im_d=0, rvalid=0, rdata=0, state IDLE.
- Reset mid-operation:
  - In-flight reads are dropped and no rvalid is produced for them.
  - An issued write is cancelled because im_wen_n is forced to 1 immediately.

## Timing
- Grant-to-pin latency is 1: if gnt[k] is asserted in cycle t, the access appears on im_a/im_wen_n/im_d in cycle t+1.
- Read latency from grant is 3: im_q is sampled at the end of t+2, and rvalid[k] and rdata are asserted in cycle t+3.
- Throughput is one access per cycle. Back-to-back reads give rvalid on consecutive cycles.
- Reads and writes can be mixed freely with no turnaround bubble.
- Simultaneous requests are resolved entirely within one cycle. Requests that lose are not recorded; the requester must keep req asserted.
- Starvation bound: a requester with a pending request is granted within 2*BURST cycles.
- With BURST=1 the arbiter is pure round-robin.

## Structure
- Shared package dpa_im_pkg:
  - AW and DW defaults.
  - Requester index constants REQ_PHOTO=0, REQ_TIME=1, REQ_HOST=2.
  - State enumeration IM_ARB_IDLE/IM_ARB_OWN.
- Sub-module rr_pick3: combinational 3-way round-robin picker. Inputs req[2:0] and a 2-bit last index; outputs a one-hot winner and a 2-bit index.
- im_arb contains the burst-lock logic, the issue register and the read-return pipeline.

## Test plan
- After reset with req=0 for 5 cycles: gnt=0, im_wen_n=1, im_a=0, rvalid=0 on every cycle.
- Requester 0 alone reads addr0=20'h00010..20'h00013 continuously: gnt[0] on 4 consecutive cycles; im_a tracks each address one cycle later; rvalid[0] on 4 consecutive cycles with rdata equal to the IM model contents.
- All three requesters held requesting with BURST=4: grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0 and so on; no requester waits more than 8 cycles.
- Requester 1 writes wdata1=24'hFFFFFF to addr1=20'h12345 while requester 2 reads the same address in the next grant: im_wen_n is low for exactly one cycle with im_a=20'h12345; the later read returns 24'hFFFFFF on rvalid[2].
- Reset asserted on the cycle after a read grant and after a write grant: no rvalid follows, im_wen_n=1 immediately, and the IM model contents are unchanged.
- BURST=1 with requesters 0 and 2 requesting: grants strictly alternate 0,2,0,2.
